// File: rtl/sa_gemm_scheduler.sv
// Weight-stationary GEMM job sequencer for an SA_SIZE x SA_SIZE systolic array.
// Loads weights, streams skewed activation rows, de-skews column results, pulses done.
module sa_gemm_scheduler #(
  parameter int unsigned SA_SIZE                = 3,
  parameter int unsigned WEIGHT_ACTIVATION_SIZE = 8,
  parameter int unsigned MAX_ROWS               = 16,
  parameter int unsigned SA_LATENCY             = 3,
  localparam int unsigned Ew   = WEIGHT_ACTIVATION_SIZE,
  localparam int unsigned CntW = $clog2(MAX_ROWS + 1),
  localparam int unsigned SelW = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CntW-1:0]       num_rows_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  weight_valid_i,
  output logic                  weight_ready_o,
  input  logic [SA_SIZE*Ew-1:0] weight_row_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SA_SIZE*Ew-1:0] in_row_i,
  output logic                  sa_weight_load_o,
  output logic [SelW-1:0]       sa_weight_sel_o,
  output logic [SA_SIZE*Ew-1:0] sa_weight_data_o,
  output logic [SA_SIZE-1:0]    sa_act_valid_o,
  output logic [SA_SIZE*Ew-1:0] sa_act_o,
  input  logic [SA_SIZE*Ew-1:0] sa_psum_i,
  output logic                  out_valid_o,
  output logic [SA_SIZE*Ew-1:0] out_row_o
);

  localparam int unsigned L = SA_LATENCY + SA_SIZE + 1;

  typedef enum logic [1:0] {StIdle, StLoadW, StStream, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   nrows_q, rcnt_q;
  logic [SelW-1:0]   wcnt_q;
  logic [L-1:0]      vld_q;
  logic              done_q, done_d;
  logic              w_hs, in_hs, last_w, last_row, pipe_empty;

  assign w_hs     = weight_valid_i & weight_ready_o;
  assign in_hs    = in_valid_i & in_ready_o;
  assign last_w   = (wcnt_q == SelW'(SA_SIZE - 1));
  assign last_row = ((rcnt_q + CntW'(1)) == nrows_q);
  // Looks one stage short of the end so done lands right after the last output row.
  assign pipe_empty = ~|vld_q[L-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StLoadW;
      StLoadW:  if (w_hs && last_w) state_d = (nrows_q == '0) ? StDrain : StStream;
      StStream: if (in_hs && last_row) state_d = StDrain;
      StDrain:  if (pipe_empty) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != StIdle);
    weight_ready_o = (state_q == StLoadW);
    in_ready_o     = (state_q == StStream);
    done_d         = (state_q == StDrain) && pipe_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nrows_q <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      if (state_q == StIdle && start_i) begin
        nrows_q <= (num_rows_i > CntW'(MAX_ROWS)) ? CntW'(MAX_ROWS) : num_rows_i;
        rcnt_q  <= '0;
        wcnt_q  <= '0;
      end else begin
        if (w_hs) wcnt_q <= wcnt_q + SelW'(1);
        if (in_hs) rcnt_q <= rcnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q           <= 1'b0;
      sa_weight_load_o <= 1'b0;
      sa_weight_sel_o  <= '0;
      sa_weight_data_o <= '0;
      vld_q            <= '0;
    end else begin
      done_q           <= done_d;
      sa_weight_load_o <= w_hs;
      if (w_hs) begin
        sa_weight_sel_o  <= wcnt_q;
        sa_weight_data_o <= weight_row_i;
      end
      vld_q <= {vld_q[L-2:0], in_hs};
    end
  end

  assign done_o      = done_q;
  assign out_valid_o = vld_q[L-1];

  // Lane k sees the accepted row k+1 cycles later; bubbles push zeros.
  for (genvar k = 0; k < SA_SIZE; k++) begin : g_skew
    logic [Ew-1:0] dat_q [k+1];
    logic          v_q   [k+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= k; j++) begin
          dat_q[j] <= '0;
          v_q[j]   <= 1'b0;
        end
      end else begin
        dat_q[0] <= in_hs ? in_row_i[k*Ew +: Ew] : '0;
        v_q[0]   <= in_hs;
        for (int j = 1; j <= k; j++) begin
          dat_q[j] <= dat_q[j-1];
          v_q[j]   <= v_q[j-1];
        end
      end
    end

    assign sa_act_o[k*Ew +: Ew] = dat_q[k];
    assign sa_act_valid_o[k]    = v_q[k];
  end

  // Column i arrives i cycles after column 0; the last stage is the output register.
  for (genvar i = 0; i < SA_SIZE; i++) begin : g_deskew
    localparam int unsigned D = SA_SIZE - i;
    logic [Ew-1:0] dsk_q [D];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < D; j++) dsk_q[j] <= '0;
      end else begin
        dsk_q[0] <= sa_psum_i[i*Ew +: Ew];
        for (int j = 1; j < D; j++) dsk_q[j] <= dsk_q[j-1];
      end
    end

    assign out_row_o[i*Ew +: Ew] = dsk_q[D-1];
  end

endmodule

// File: tb/tb_sa_gemm_scheduler.sv
// Scoreboard bench for sa_gemm_scheduler with a behavioural systolic-array model
// fed from the DUT's skewed lanes and weight strobes.
module tb_sa_gemm_scheduler;
  localparam int N = 3;
  localparam int W = 8;
  localparam int LAT = 3;
  localparam int L = LAT + N + 1;
  localparam int HIST = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic [4:0] num_rows_i = '0;
  logic busy_o, done_o;
  logic weight_valid_i = 1'b0;
  logic weight_ready_o;
  logic [N*W-1:0] weight_row_i = '0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [N*W-1:0] in_row_i = '0;
  logic sa_weight_load_o;
  logic [1:0] sa_weight_sel_o;
  logic [N*W-1:0] sa_weight_data_o;
  logic [N-1:0] sa_act_valid_o;
  logic [N*W-1:0] sa_act_o;
  logic [N*W-1:0] sa_psum_i = '0;
  logic out_valid_o;
  logic [N*W-1:0] out_row_o;

  sa_gemm_scheduler dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_rows_i(num_rows_i),
    .busy_o(busy_o), .done_o(done_o),
    .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_o),
    .weight_row_i(weight_row_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_row_i(in_row_i),
    .sa_weight_load_o(sa_weight_load_o), .sa_weight_sel_o(sa_weight_sel_o),
    .sa_weight_data_o(sa_weight_data_o),
    .sa_act_valid_o(sa_act_valid_o), .sa_act_o(sa_act_o), .sa_psum_i(sa_psum_i),
    .out_valid_o(out_valid_o), .out_row_o(out_row_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [N*W-1:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rst_cyc = -1;

  logic [N*W-1:0] job_w [N];
  logic [N*W-1:0] job_rows [32];
  logic [N*W-1:0] lane_hist [HIST];
  logic           acc_hist [HIST];
  logic [N*W-1:0] arr_w [N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*W-1:0] pack3(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  // out[i] = sum_j in[j] * W[j][i] mod 256, from the job's own weight matrix.
  function automatic logic [N*W-1:0] ref_row(input logic [N*W-1:0] r);
    logic [N*W-1:0] res;
    logic [W-1:0]   a, b;
    int s;
    res = '0;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < N; j++) begin
        a = r[j*W +: W];
        b = job_w[j][i*W +: W];
        s = s + int'(a) * int'(b);
      end
      res[i*W +: W] = W'(s % 256);
    end
    return res;
  endfunction

  // Array model + monitor, sampled away from the active edge.
  always @(negedge clk) begin
    logic [N*W-1:0] ps;
    logic [N-1:0]   exp_v;
    logic [W-1:0]   acc8, a, b;
    logic [2*W-1:0] prod;
    int             idx;
    exp_t           e;
    int             dc;

    lane_hist[cyc] = (cyc == 0) ? '0 : sa_act_o;
    acc_hist[cyc]  = in_valid_i & in_ready_o & ~rst;
    if (sa_weight_load_o === 1'b1 && sa_weight_sel_o < 2'(N))
      arr_w[sa_weight_sel_o] = sa_weight_data_o;

    ps = '0;
    for (int i = 0; i < N; i++) begin
      acc8 = '0;
      for (int k = 0; k < N; k++) begin
        idx = cyc - LAT - i + k;
        if (idx >= 0) begin
          a    = lane_hist[idx][k*W +: W];
          b    = arr_w[k][i*W +: W];
          prod = a * b;
          acc8 = acc8 + prod[W-1:0];
        end
      end
      ps[i*W +: W] = acc8;
    end
    sa_psum_i = ps;

    if (cyc >= 1) begin
      for (int k = 0; k < N; k++) begin
        idx = cyc - 1 - k;
        exp_v[k] = (idx >= 0 && idx > rst_cyc) ? acc_hist[idx] : 1'b0;
      end
      checks++;
      if (sa_act_valid_o !== exp_v) begin
        failures++;
        $display("FAIL lane_valid cyc=%0d got=%b exp=%b", cyc, sa_act_valid_o, exp_v);
      end

      if (out_valid_o !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out cyc=%0d got=%h exp=none", cyc, out_row_o);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || out_row_o !== e.row) begin
            failures++;
            $display("FAIL out_row cyc=%0d got=%h exp=%h at cyc %0d", cyc, out_row_o, e.row,
                     e.cyc);
          end
        end
      end

      if (done_o !== 1'b0) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d got=1 exp=0", cyc);
        end else begin
          dc = done_q.pop_front();
          if (dc != cyc) begin
            failures++;
            $display("FAIL done_time got=%0d exp=%0d", cyc, dc);
          end
        end
      end
    end
    if (rst) rst_cyc = cyc;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic run_job(input int n, input int offer, input int bub_pct, input int gap,
                         input bit mid_start, input int abort_at);
    int n_eff, acc, idx, guard, k, h, hold;
    bit aborted;
    n_eff = (n > 16) ? 16 : n;
    acc = 0; idx = 0; h = 0; hold = 0; aborted = 1'b0;

    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("idle_wait", int'(busy_o), 0);

    @(posedge clk); #1;
    start_i = 1'b1;
    num_rows_i = 5'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
    num_rows_i = 5'($urandom);

    k = 0; guard = 0;
    while (k < N && guard < 100) begin
      weight_valid_i = ($urandom_range(0, 99) >= bub_pct);
      weight_row_i   = job_w[k];
      @(negedge clk);
      if (weight_valid_i && weight_ready_o) begin
        h = cyc;
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    weight_valid_i = 1'b0;
    check("weights_loaded", k, N);
    if (n_eff == 0) done_q.push_back(h + 2);

    guard = 0;
    while (guard < 400) begin
      start_i = (mid_start && guard == 2);
      num_rows_i = start_i ? 5'd1 : num_rows_i;
      in_valid_i = (idx < offer) && (hold == 0) && ($urandom_range(0, 99) >= bub_pct);
      in_row_i = (idx < offer) ? job_rows[idx] : '0;
      if (hold > 0) hold--;
      @(negedge clk);
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back('{cyc: cyc + L, row: ref_row(job_rows[idx])});
        acc++;
        idx++;
        hold = gap;
        if (acc == n_eff) done_q.push_back(cyc + L + 1);
        if (acc == abort_at) begin
          aborted = 1'b1;
          break;
        end
      end
      if (!busy_o) break;
      @(posedge clk); #1;
      guard++;
    end
    in_valid_i = 1'b0;
    start_i = 1'b0;

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      done_q.delete();
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_idle", int'(busy_o), 0);
      repeat (15) @(negedge clk);
    end else begin
      check("rows_accepted", acc, n_eff);
    end
  endtask

  initial begin
    repeat (3) begin
      @(posedge clk); #1;
      start_i = 1'($urandom);
      num_rows_i = 5'($urandom);
      weight_valid_i = 1'($urandom);
      weight_row_i = 24'($urandom);
      in_valid_i = 1'($urandom);
      in_row_i = 24'($urandom);
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, weight_ready_o, in_ready_o, sa_weight_load_o, sa_weight_sel_o,
           sa_weight_data_o, sa_act_valid_o, sa_act_o, out_valid_o, out_row_o} !== '0) begin
        failures++;
        $display("FAIL reset_outputs got busy=%b rdy=%b/%b out_v=%b exp all zero",
                 busy_o, weight_ready_o, in_ready_o, out_valid_o);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start_i = 1'b0;
    weight_valid_i = 1'b0;
    in_valid_i = 1'b0;

    // Diagonal weights
    job_w[0] = pack3(3, 0, 0);
    job_w[1] = pack3(0, 2, 0);
    job_w[2] = pack3(0, 0, 5);
    job_rows[0] = pack3(2, 5, 6);
    job_rows[1] = pack3(4, 15, 24);
    run_job(2, 2, 0, 0, 1'b0, -1);

    // Wrap-around mod 256
    job_w[0] = pack3(3, 255, 1);
    job_w[1] = pack3(4, 2, 7);
    job_w[2] = pack3(23, 42, 5);
    job_rows[0] = pack3(1, 1, 0);
    run_job(1, 1, 0, 0, 1'b0, -1);

    // 2-cycle bubbles between rows
    for (int r = 0; r < 4; r++) job_rows[r] = 24'($urandom);
    run_job(4, 4, 0, 2, 1'b0, -1);

    // Zero-row job, then clamped oversized job
    run_job(0, 0, 0, 0, 1'b0, -1);
    for (int r = 0; r < 20; r++) job_rows[r] = 24'($urandom);
    run_job(20, 20, 20, 0, 1'b0, -1);

    // Start pulsed mid-stream is ignored; reset mid-stream aborts
    for (int r = 0; r < 8; r++) job_rows[r] = 24'($urandom);
    run_job(5, 5, 10, 0, 1'b1, -1);
    run_job(8, 8, 0, 0, 1'b0, 3);

    // Random jobs
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N; k++) job_w[k] = 24'($urandom);
      for (int r = 0; r < 16; r++) job_rows[r] = 24'($urandom);
      run_job(int'($urandom_range(1, 16)), 16, 30, 0, 1'b0, -1);
    end

    repeat (20) @(negedge clk);
    check("pending_outputs", exp_q.size(), 0);
    check("pending_done", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
